// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between NUM_REQ requesters.
// Serves one transaction at a time and returns read data with a one-cycle done pulse.
module mem_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 12,
  parameter int MEM_LATENCY = 2
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [SEL_W-1:0]         r_sel;
  logic [SEL_W-1:0]         r_ptr;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_mem_we;
  logic [ADDR_W-1:0]        r_mem_addr;
  logic [DATA_W-1:0]        r_mem_wdata;
  logic [DATA_W-1:0]        r_rdata;

  logic [2*NUM_REQ-1:0]     w_rot;
  logic                     w_any;
  logic [SEL_W:0]           w_sum;
  logic [SEL_W-1:0]         w_pick;
  logic                     w_we;
  logic [ADDR_W-1:0]        w_addr;
  logic [DATA_W-1:0]        w_wdata;
  logic [SEL_W-1:0]         w_ptr_next;

  // Rotating the doubled request vector by the pointer puts the highest-priority requester at bit 0.
  assign w_rot = {req, req} >> r_ptr;
  assign w_ptr_next = (r_sel == SEL_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;

  always_comb begin
    w_any   = |req;
    w_sum   = '0;
    w_pick  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum  = {1'b0, r_ptr} + (SEL_W+1)'(k);
        w_pick = (w_sum >= (SEL_W+1)'(NUM_REQ)) ? SEL_W'(w_sum - (SEL_W+1)'(NUM_REQ))
                                                 : w_sum[SEL_W-1:0];
      end
    end
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == SEL_W'(i)) begin
        w_we    = we[i];
        w_addr  = addr[i*ADDR_W +: ADDR_W];
        w_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // WAIT is always visited so rdata is captured exactly MEM_LATENCY cycles after mem_en.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_sel       <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel       <= w_pick;
            r_mem_we    <= w_we;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
          end
        end
        S_ISSUE: r_cnt <= CNT_W'(MEM_LATENCY - 1);
        S_WAIT: begin
          if (r_cnt != '0)    r_cnt   <= r_cnt - 1'b1;
          else if (!r_mem_we) r_rdata <= mem_rdata;
        end
        S_DONE:  r_ptr <= w_ptr_next;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy   = (r_state != S_IDLE);
    mem_en = (r_state == S_ISSUE);
    gnt    = (r_state != S_IDLE) ? (NUM_REQ'(1) << r_sel) : '0;
    done   = (r_state == S_DONE) ? (NUM_REQ'(1) << r_sel) : '0;
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-latency memory model, transaction-level reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
  localparam int NUM_REQ     = 3;
  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 12;
  localparam int MEM_LATENCY = 2;
  localparam int TXN_LEN     = MEM_LATENCY + 3;

  logic                      clock;
  logic                      resetN;
  logic [NUM_REQ-1:0]        req, we, gnt, done;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]         rdata, mem_wdata, mem_rdata;
  logic                      busy, mem_en, mem_we;
  logic [ADDR_W-1:0]         mem_addr;

  mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(MEM_LATENCY)) dut (
    .clock(clock), .resetN(resetN), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int n_memen = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (mem_en) n_memen <= n_memen + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return (a == 12'o0200) ? 12'o7402 : (a ^ 12'o3135);
  endfunction

  // Memory environment: writes on mem_en, read data appears MEM_LATENCY cycles later.
  logic [DATA_W-1:0] mem    [0:(1<<ADDR_W)-1];
  logic              mem_wr [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] pd     [0:MEM_LATENCY-1];
  logic              pv     [0:MEM_LATENCY-1];
  always @(posedge clock) begin
    if (cyc < 2) for (int a = 0; a < (1<<ADDR_W); a++) mem_wr[a] <= 1'b0;
    if (mem_en && mem_we) begin
      mem[mem_addr]    <= mem_wdata;
      mem_wr[mem_addr] <= 1'b1;
    end
    pd[0] <= mem_wr[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    pv[0] <= mem_en && !mem_we;
    for (int k = 1; k < MEM_LATENCY; k++) begin
      pd[k] <= pd[k-1];
      pv[k] <= pv[k-1];
    end
  end
  assign mem_rdata = pv[MEM_LATENCY-1] ? pd[MEM_LATENCY-1] : 12'o5555;

  // Reference model: a transaction occupies MEM_LATENCY+2 cycles starting at its ISSUE cycle (m_t = 0).
  logic              m_act, m_we;
  int                m_t, m_sel, m_ptr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  logic              ref_wr  [0:(1<<ADDR_W)-1];

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      m_act <= 1'b0; m_t <= 0; m_sel <= 0; m_ptr <= 0;
      m_we <= 1'b0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
      if (cyc < 2) for (int a = 0; a < (1<<ADDR_W); a++) ref_wr[a] <= 1'b0;
    end else if (m_act) begin
      if (m_t == MEM_LATENCY + 1) begin
        m_act <= 1'b0;
        m_ptr <= (m_sel + 1) % NUM_REQ;
      end else begin
        m_t <= m_t + 1;
        if (m_t == MEM_LATENCY && !m_we)
          m_rdata <= ref_wr[m_addr] ? ref_mem[m_addr] : init_val(m_addr);
      end
    end else if (req != '0) begin
      int w;
      w = -1;
      for (int k = 0; k < NUM_REQ; k++)
        if (w < 0 && req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
      m_act   <= 1'b1;
      m_t     <= 0;
      m_sel   <= w;
      m_we    <= we[w];
      m_addr  <= addr[w*ADDR_W +: ADDR_W];
      m_wdata <= wdata[w*DATA_W +: DATA_W];
      if (we[w]) begin
        ref_mem[addr[w*ADDR_W +: ADDR_W]] <= wdata[w*DATA_W +: DATA_W];
        ref_wr[addr[w*ADDR_W +: ADDR_W]]  <= 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    chk("cmp_busy",      32'(busy),      32'(m_act));
    chk("cmp_gnt",       32'(gnt),       m_act ? (32'd1 << m_sel) : 32'd0);
    chk("cmp_done",      32'(done),      (m_act && m_t == MEM_LATENCY + 1) ? (32'd1 << m_sel) : 32'd0);
    chk("cmp_mem_en",    32'(mem_en),    32'(m_act && m_t == 0));
    chk("cmp_mem_we",    32'(mem_we),    32'(m_we));
    chk("cmp_mem_addr",  32'(mem_addr),  32'(m_addr));
    chk("cmp_mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("cmp_rdata",     32'(rdata),     32'(m_rdata));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  int order  [0:7];
  int en_cyc [0:7];
  int n_done = 0;
  int n_en   = 0;
  int m0;

  initial begin
    resetN = 1'b0;
    we     = '0;
    wdata  = '0;
    req    = 3'b111;
    addr   = {12'o0102, 12'o0101, 12'o0100};
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);

    // Round-robin with all three requests held from reset release.
    resetN = 1'b1;
    for (int i = 1; i <= 29; i++) begin
      tick(1);
      if (done != '0 && n_done < 8) begin order[n_done] = oh_idx(done); n_done++; end
      if (mem_en && n_en < 8) begin en_cyc[n_en] = cyc; n_en++; end
      if (i == 29) req = '0;
    end
    chk("rr_done_count", 32'(n_done), 6);
    chk("rr_mem_en_count", 32'(n_en), 6);
    for (int k = 0; k < 6; k++) chk("rr_order", 32'(order[k]), 32'(k % 3));
    for (int k = 0; k < 5; k++) chk("rr_spacing", 32'(en_cyc[k+1] - en_cyc[k]), TXN_LEN);

    // Single read of 0200.
    tick(1);
    addr[0 +: ADDR_W] = 12'o0200;
    req = 3'b001;
    tick(1);
    chk("rd_mem_en", 32'(mem_en), 1);
    chk("rd_mem_addr", 32'(mem_addr), 32'(12'o0200));
    chk("rd_mem_we", 32'(mem_we), 0);
    tick(3);
    chk("rd_done", 32'(done), 32'b001);
    chk("rd_rdata", 32'(rdata), 32'(12'o7402));
    req = '0;
    tick(1);
    chk("rd_busy_low", 32'(busy), 0);

    // Single write by requester 2; rdata must hold.
    addr[2*ADDR_W +: ADDR_W]  = 12'o0017;
    wdata[2*DATA_W +: DATA_W] = 12'o1234;
    we  = 3'b100;
    req = 3'b100;
    tick(1);
    chk("wr_mem_en", 32'(mem_en), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'(12'o1234));
    tick(3);
    chk("wr_done", 32'(done), 32'b100);
    chk("wr_rdata_hold", 32'(rdata), 32'(12'o7402));
    req = '0;
    we  = '0;
    tick(1);
    addr[0 +: ADDR_W] = 12'o0017;
    req = 3'b001;
    tick(4);
    chk("rdback_done", 32'(done), 32'b001);
    chk("rdback_rdata", 32'(rdata), 32'(12'o1234));
    req = '0;
    tick(1);

    // Pointer wrap: serve 2 alone, then 0 and 1 together.
    addr[2*ADDR_W +: ADDR_W] = 12'o0020;
    req = 3'b100;
    tick(4);
    chk("wrap_done2", 32'(done), 32'b100);
    req = '0;
    tick(1);
    req = 3'b011;
    tick(1);
    chk("wrap_first_gnt", 32'(gnt), 32'b001);
    tick(3);
    chk("wrap_first_done", 32'(done), 32'b001);
    req = 3'b010;
    tick(2);
    chk("wrap_second_gnt", 32'(gnt), 32'b010);
    tick(3);
    chk("wrap_second_done", 32'(done), 32'b010);
    req = '0;
    tick(1);

    // Early drop of req[1] during WAIT.
    m0 = n_memen;
    req = 3'b010;
    tick(2);
    req = '0;
    tick(2);
    chk("drop_done", 32'(done), 32'b010);
    tick(1);
    chk("drop_busy_low", 32'(busy), 0);
    chk("drop_single_mem_en", 32'(n_memen - m0), 1);

    // Asynchronous reset in the WAIT cycle.
    addr[2*ADDR_W +: ADDR_W] = 12'o0300;
    req = 3'b100;
    tick(3);
    #1 resetN = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_mem_en", 32'(mem_en), 0);
    req = '0;
    tick(2);
    resetN = 1'b1;
    tick(3);
    chk("arst_no_done", 32'(done), 0);
    req = 3'b110;
    tick(1);
    chk("arst_ptr0_gnt", 32'(gnt), 32'b010);
    tick(3);
    chk("arst_ptr0_done", 32'(done), 32'b010);
    req = '0;
    tick(1);
    addr[0 +: ADDR_W] = 12'o0200;
    req = 3'b001;
    tick(1);
    chk("arst_req0_gnt", 32'(gnt), 32'b001);
    tick(3);
    chk("arst_req0_done", 32'(done), 32'b001);
    chk("arst_req0_rdata", 32'(rdata), 32'(12'o7402));
    req = '0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
